// File: rtl/tsi_pkg.sv
// Shared definitions for the TSI frame aligner and the switch bench.
// Holds the frame geometry, the default alignment word, the default
// confirm/loss hysteresis depths and the aligner FSM state encoding.
package tsi_pkg;

  localparam int SLOTS = 32;
  localparam int BITS = 8;
  localparam int POS_W = $clog2(SLOTS * BITS);

  localparam logic [7:0] FAS_DEFAULT = 8'h1B;
  localparam int CONFIRM_DEFAULT = 3;
  localparam int LOSS_DEFAULT = 3;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } tsi_state_e;

endpackage

// File: rtl/tsi_fas_detect.sv
// Alignment word detector: a BITS-wide shift register that takes the serial
// stream LSB first, plus a comparator against the alignment word.
// Ports:
//   clk      - clock
//   reset    - asynchronous active-low reset (clears the shift register)
//   shift_en - a new bit is present on bit_in this cycle
//   bit_in   - serial input bit
//   match    - the window including the current bit equals FAS
module tsi_fas_detect
  import tsi_pkg::*;
#(
  parameter logic [BITS-1:0] FAS = FAS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [BITS-1:0] sr;
  logic [BITS-1:0] sr_next;

  // The newest bit lands in the MSB so that after a full slot the byte
  // reads naturally with its first-received bit as bit 0.
  assign sr_next = {bit_in, sr[BITS-1:1]};

  // Compare the post-shift window so the decision includes this cycle's bit.
  assign match = shift_en && (sr_next == FAS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_next;
    end
  end

endmodule

// File: rtl/tsi_frame_aligner.sv
// Frame aligner for one serial input stream of the TSI switch.
// Hunts for the alignment word in slot 0, confirms it over several frames,
// then tracks slot/bit position and qualifies the stream toward the switch.
// Ports:
//   clk         - clock
//   reset       - asynchronous active-low reset
//   bit_valid   - stream_in carries a bit this cycle
//   stream_in   - serial bit, LSB of each slot first
//   data_out    - stream_in delayed one cycle
//   data_valid  - data_out is an aligned bit (SYNC only)
//   frame_start - pulse with slot 0 bit 0 on data_out
//   slot_cnt    - slot index of data_out
//   bit_cnt     - bit index of data_out
//   in_sync     - state is SYNC
//   fas_err     - one-cycle pulse per alignment word mismatch in PRESYNC/SYNC
module tsi_frame_aligner #(
  parameter int         SLOTS   = tsi_pkg::SLOTS,
  parameter int         BITS    = tsi_pkg::BITS,
  parameter logic [7:0] FAS     = tsi_pkg::FAS_DEFAULT,
  parameter int         CONFIRM = tsi_pkg::CONFIRM_DEFAULT,
  parameter int         LOSS    = tsi_pkg::LOSS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_valid,
  input  logic                     stream_in,
  output logic                     data_out,
  output logic                     data_valid,
  output logic                     frame_start,
  output logic [$clog2(SLOTS)-1:0] slot_cnt,
  output logic [$clog2(BITS)-1:0]  bit_cnt,
  output logic                     in_sync,
  output logic                     fas_err
);

  import tsi_pkg::*;

  localparam int BIT_W = $clog2(BITS);
  localparam int POS_BITS = $clog2(SLOTS * BITS);
  localparam int CNT_W = 4;

  localparam logic [POS_BITS-1:0] FAS_LAST_POS = POS_BITS'(BITS - 1);
  localparam logic [POS_BITS-1:0] AFTER_FAS_POS = POS_BITS'(BITS);
  localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS);

  tsi_state_e          state;
  logic [POS_BITS-1:0] pos;
  logic [CNT_W-1:0]    good_cnt;
  logic [CNT_W-1:0]    bad_cnt;
  logic                match;

  tsi_fas_detect #(
    .FAS(FAS)
  ) u_fas_detect (
    .clk     (clk),
    .reset   (reset),
    .shift_en(bit_valid),
    .bit_in  (stream_in),
    .match   (match)
  );

  // Single FSM block: it owns the position counter, the hysteresis counters
  // and every registered output. The output qualifiers use the state as it
  // was before this bit's transition, so the confirming bit is not yet
  // valid while the bit that completes a loss still is. In HUNT the position
  // is parked at 0 because it means nothing until an alignment word is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      pos         <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      slot_cnt    <= '0;
      bit_cnt     <= '0;
      in_sync     <= 1'b0;
      fas_err     <= 1'b0;
    end else begin
      data_out    <= stream_in;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      fas_err     <= 1'b0;
      if (bit_valid) begin
        slot_cnt    <= pos[POS_BITS-1:BIT_W];
        bit_cnt     <= pos[BIT_W-1:0];
        data_valid  <= (state == SYNC);
        frame_start <= (state == SYNC) && (pos == '0);
        pos         <= pos + 1'b1;
        unique case (state)
          HUNT: begin
            if (match) begin
              pos      <= AFTER_FAS_POS;
              good_cnt <= CNT_W'(1);
              bad_cnt  <= '0;
              if (CONFIRM <= 1) begin
                state   <= SYNC;
                in_sync <= 1'b1;
              end else begin
                state <= PRESYNC;
              end
            end else begin
              pos <= '0;
            end
          end
          PRESYNC: begin
            if (pos == FAS_LAST_POS) begin
              if (match) begin
                good_cnt <= good_cnt + 1'b1;
                if (good_cnt + 1'b1 == CONFIRM_C) begin
                  state   <= SYNC;
                  in_sync <= 1'b1;
                  bad_cnt <= '0;
                end
              end else begin
                fas_err  <= 1'b1;
                state    <= HUNT;
                good_cnt <= '0;
                pos      <= '0;
              end
            end
          end
          SYNC: begin
            if (pos == FAS_LAST_POS) begin
              if (match) begin
                bad_cnt <= '0;
              end else begin
                fas_err <= 1'b1;
                bad_cnt <= bad_cnt + 1'b1;
                // Losing sync overrides everything else on this bit.
                if (bad_cnt + 1'b1 == LOSS_C) begin
                  state    <= HUNT;
                  in_sync  <= 1'b0;
                  bad_cnt  <= '0;
                  good_cnt <= '0;
                  pos      <= '0;
                end
              end
            end
          end
          default: begin
            state   <= HUNT;
            in_sync <= 1'b0;
            pos     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tsi_frame_aligner.sv
// Self-checking bench for tsi_frame_aligner: directed frame scenarios plus a
// randomized phase, all checked every cycle against a behavioural model that
// tracks frame phase and sync status from the serial bits it receives.
module tb_tsi_frame_aligner;

  localparam logic [7:0] FAS = 8'h1B;
  localparam logic [7:0] BAD = 8'h1A;
  localparam int CONFIRM = 3;
  localparam int LOSS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_valid = 1'b0;
  logic       stream_in = 1'b0;
  logic       data_out;
  logic       data_valid;
  logic       frame_start;
  logic [4:0] slot_cnt;
  logic [2:0] bit_cnt;
  logic       in_sync;
  logic       fas_err;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: 0 hunting, 1 confirming, 2 locked.
  int   mState = 0;
  int   mPos = 0;
  int   mGood = 0;
  int   mBad = 0;
  bit   mBits[$];
  logic [7:0] cand;
  logic expDataOut = 0, expValid = 0, expFs = 0, expErr = 0, expSync = 0;
  int   expSlot = 0, expBit = 0;
  int   validCount = 0;
  int   errSeen = 0;
  int   lastFs = -1;
  bit   checkEn = 0;

  always #5 clk = ~clk;

  tsi_frame_aligner #(
    .SLOTS(32), .BITS(8), .FAS(FAS), .CONFIRM(CONFIRM), .LOSS(LOSS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .stream_in  (stream_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_start(frame_start),
    .slot_cnt   (slot_cnt),
    .bit_cnt    (bit_cnt),
    .in_sync    (in_sync),
    .fas_err    (fas_err)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural reference: the last eight received bits form the candidate
  // word (first received = bit 0), the frame phase is an integer modulo 256,
  // and sync status follows the confirm/loss counting rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mState = 0; mPos = 0; mGood = 0; mBad = 0;
      mBits.delete();
      expDataOut = 0; expValid = 0; expFs = 0; expErr = 0; expSync = 0;
      expSlot = 0; expBit = 0;
    end else begin
      expDataOut = stream_in;
      expValid = 0; expFs = 0; expErr = 0;
      if (bit_valid) begin
        validCount++;
        mBits.push_back(stream_in);
        if (mBits.size() > 8) mBits.delete(0);
        cand = '0;
        for (int i = 0; i < mBits.size(); i++) cand[8 - mBits.size() + i] = mBits[i];
        expValid = (mState == 2);
        expFs = expValid && (mPos == 0);
        expSlot = mPos / 8;
        expBit = mPos % 8;
        if (mState == 0) begin
          if (cand == FAS) begin
            mState = (CONFIRM == 1) ? 2 : 1;
            mGood = 1; mBad = 0; mPos = 8;
          end else begin
            mPos = (mPos + 1) % 256;
          end
        end else if (mPos == 7) begin
          if (mState == 1) begin
            if (cand == FAS) begin
              mGood++;
              if (mGood >= CONFIRM) begin mState = 2; mBad = 0; end
            end else begin
              expErr = 1; mState = 0; mGood = 0;
            end
          end else begin
            if (cand == FAS) mBad = 0;
            else begin
              expErr = 1; mBad++;
              if (mBad >= LOSS) begin mState = 0; mBad = 0; mGood = 0; end
            end
          end
          mPos = 8;
        end else begin
          mPos = (mPos + 1) % 256;
        end
      end
      expSync = (mState == 2);
    end
  end

  // Every-cycle comparison against the model, plus frame_start spacing
  // measured in valid bits while the DUT stays locked.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("data_out", data_out, expDataOut);
      checkOutput("data_valid", data_valid, expValid);
      checkOutput("frame_start", frame_start, expFs);
      checkOutput("fas_err", fas_err, expErr);
      checkOutput("in_sync", in_sync, expSync);
      if (expValid) begin
        checkOutput("slot_cnt", slot_cnt, expSlot);
        checkOutput("bit_cnt", bit_cnt, expBit);
      end
      if (fas_err) errSeen++;
      if (!in_sync) lastFs = -1;
      else if (frame_start) begin
        if (lastFs >= 0) checkOutput("fs_spacing", validCount - lastFs, 256);
        lastFs = validCount;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic b);
    @(negedge clk);
    bit_valid = v;
    stream_in = b;
  endtask

  task automatic waitSample();
    @(posedge clk);
    #1;
  endtask

  task automatic sendSlot(input logic [7:0] val, input int gapPct);
    for (int i = 0; i < 8; i++) begin
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct)
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      applyStimulus(1'b1, val[i]);
    end
  endtask

  task automatic sendPayload(input int fromSlot, input int fakeSlot, input bit randData,
                             input int gapPct);
    logic [7:0] b;
    for (int s = fromSlot; s < 32; s++) begin
      b = randData ? 8'($urandom_range(0, 255)) : 8'h00;
      if (s == fakeSlot) b = FAS;
      sendSlot(b, gapPct);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, data_out, 0);
    checkOutput({tag, "_data_valid"}, data_valid, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_slot_cnt"}, slot_cnt, 0);
    checkOutput({tag, "_bit_cnt"}, bit_cnt, 0);
    checkOutput({tag, "_in_sync"}, in_sync, 0);
    checkOutput({tag, "_fas_err"}, fas_err, 0);
  endtask

  // Three clean alignment frames from HUNT; lock appears the cycle after the
  // third word's last bit and that bit itself is not yet valid.
  task automatic syncUp(input string tag);
    for (int f = 0; f < 3; f++) begin
      sendSlot(FAS, 0);
      if (f == 1) begin
        waitSample();
        checkOutput({tag, "_presync_hold"}, in_sync, 0);
      end
      if (f == 2) begin
        waitSample();
        checkOutput({tag, "_sync_rise"}, in_sync, 1);
        checkOutput({tag, "_confirm_bit_invalid"}, data_valid, 0);
      end
      sendPayload(1, -1, 0, 0);
    end
  endtask

  initial begin
    int errBefore;
    logic [7:0] s0;

    // Reset asserted, outputs must sit at zero.
    #1 reset = 1'b0;
    checkEn = 1;
    repeat (3) @(negedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    #2 reset = 1'b1;

    // Idle zero stream never aligns.
    repeat (600) applyStimulus(1'b1, 1'b0);
    waitSample();
    checkOutput("idle_in_sync", in_sync, 0);
    checkOutput("idle_fas_err_count", errSeen, 0);

    // False alignment word in slot 5 followed by a frame without it.
    sendSlot(8'h00, 0);
    sendPayload(1, 5, 0, 0);
    for (int s = 0; s < 5; s++) sendSlot(8'h00, 0);
    errBefore = errSeen;
    sendSlot(8'h00, 0);
    waitSample();
    checkOutput("false_fas_err_pulse", fas_err, 1);
    sendPayload(6, -1, 0, 0);
    checkOutput("false_fas_err_count", errSeen - errBefore, 1);
    checkOutput("false_fas_back_hunt", in_sync, 0);

    syncUp("first");
    repeat (2) begin sendSlot(FAS, 0); sendPayload(1, -1, 0, 0); end

    // Two bad words then a good one: errors but lock survives.
    errBefore = errSeen;
    repeat (2) begin sendSlot(BAD, 0); sendPayload(1, -1, 0, 0); end
    sendSlot(FAS, 0);
    sendPayload(1, -1, 0, 0);
    checkOutput("two_bad_err_count", errSeen - errBefore, 2);
    checkOutput("two_bad_still_sync", in_sync, 1);

    // Three bad words lose lock; the losing bit is still valid.
    repeat (2) begin sendSlot(BAD, 0); sendPayload(1, -1, 0, 0); end
    sendSlot(BAD, 0);
    waitSample();
    checkOutput("loss_in_sync", in_sync, 0);
    checkOutput("loss_bit_valid", data_valid, 1);
    sendPayload(1, -1, 0, 0);
    syncUp("after_loss");

    // Five-cycle gap in the middle of slot 12 while locked.
    sendSlot(FAS, 0);
    for (int s = 1; s < 12; s++) sendSlot(8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    for (int g = 0; g < 5; g++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      waitSample();
      checkOutput("gap_data_valid", data_valid, 0);
      checkOutput("gap_slot_hold", slot_cnt, 12);
      checkOutput("gap_bit_hold", bit_cnt, 3);
    end
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b0);
    sendPayload(13, -1, 0, 0);
    sendSlot(FAS, 0);
    sendPayload(1, -1, 0, 0);
    checkOutput("gap_keeps_sync", in_sync, 1);

    // Reset pulse in the middle of slot 20 while locked.
    sendSlot(FAS, 0);
    for (int s = 1; s < 20; s++) sendSlot(8'h00, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("midreset");
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b0);
    sendPayload(21, -1, 0, 0);
    syncUp("after_reset");

    // Randomized frames: mostly good alignment words, random payload and gaps.
    for (int f = 0; f < 30; f++) begin
      s0 = ($urandom_range(0, 99) < 75) ? FAS : 8'($urandom_range(0, 255));
      sendSlot(s0, 5);
      sendPayload(1, -1, 1, 5);
    end
    applyStimulus(1'b0, 1'b0);
    repeat (2) @(negedge clk);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
